// File: rtl/ahb_ic_pkg.sv
// Shared types, HTRANS encodings and decode helpers for the Triple-DES AHB-Lite interconnect.
// Imported by the interconnect top and the wait-state watchdog.
package ahb_ic_pkg;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_DATA = 2'd1,
        IC_ERR1 = 2'd2,
        IC_ERR2 = 2'd3
    } ic_state_t;

    typedef enum logic {
        SEL_DEF = 1'b0,
        SEL_DES = 1'b1
    } slave_sel_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return ((addr & mask) == base);
    endfunction

    function automatic logic trans_active(input logic [1:0] trans);
        return ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));
    endfunction

endpackage

// File: rtl/ahb_watchdog.sv
// Data-phase wait-state counter; expire pulses when the TIMEOUT-th consecutive
// wait cycle is still not ready.
module ahb_watchdog
    import ahb_ic_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_r;

    assign expire = inc && (count_r == LAST);

    // Wait counter: cleared on every accepted address phase, counts stalled data cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else if (inc && !expire) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/ahb_interconnect.sv
// Single-master AHB-Lite interconnect: DES register slave plus default slave,
// with a wait-state watchdog that aborts and quarantines a hung DES slave.
module ahb_interconnect
    import ahb_ic_pkg::*;
#(
    parameter logic [31:0] DES_BASE = 32'h0000_0000,
    parameter logic [31:0] DES_MASK = 32'hFFFF_F000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned DATA_W   = 64
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    output logic              HSEL_DES,
    output logic              HSEL_DEF,
    input  logic              HREADYOUT_DES,
    input  logic              HREADYOUT_DEF,
    input  logic              HRESP_DES,
    input  logic              HRESP_DEF,
    input  logic [DATA_W-1:0] HRDATA_DES,
    input  logic [DATA_W-1:0] HRDATA_DEF,
    output logic              HREADY,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA,
    output logic              TIMEOUT_FLAG,
    output logic              QUARANTINE,
    output logic [7:0]        ERR_COUNT
);

    ic_state_t   state_r;
    ic_state_t   state_nxt_s;
    slave_sel_t  sel_r;
    logic        hit_s;
    logic        ready_s;
    logic        resp_s;
    logic [DATA_W-1:0] rdata_s;
    logic        wait_inc_s;
    logic        expire_s;
    logic        timeout_flag_r;
    logic        quarantine_r;
    logic [7:0]  err_count_r;

    assign hit_s    = addr_hit(HADDR, DES_BASE, DES_MASK) && !quarantine_r;
    assign HSEL_DES = hit_s;
    assign HSEL_DEF = !hit_s;

    assign HREADY       = ready_s;
    assign HRESP        = resp_s;
    assign HRDATA       = rdata_s;
    assign TIMEOUT_FLAG = timeout_flag_r;
    assign QUARANTINE   = quarantine_r;
    assign ERR_COUNT    = err_count_r;

    assign wait_inc_s = (state_r == IC_DATA) && !ready_s;

    ahb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (HCLK),
        .rst    (HRESET),
        .clr    (ready_s),
        .inc    (wait_inc_s),
        .expire (expire_s)
    );

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r <= IC_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: any ready cycle accepts a new address phase.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IC_IDLE, IC_DATA, IC_ERR2: begin
                if (ready_s) begin
                    state_nxt_s = trans_active(HTRANS) ? IC_DATA : IC_IDLE;
                end else if (expire_s) begin
                    state_nxt_s = IC_ERR1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            IC_ERR1: state_nxt_s = IC_ERR2;
            default: state_nxt_s = IC_IDLE;
        endcase
    end

    // Response mux: pass the registered slave through in DATA, synthesize the rest.
    always_comb begin
        ready_s = 1'b1;
        resp_s  = 1'b0;
        rdata_s = {DATA_W{1'b0}};
        case (state_r)
            IC_IDLE: begin
                ready_s = 1'b1;
                resp_s  = 1'b0;
            end
            IC_DATA: begin
                if (sel_r == SEL_DES) begin
                    ready_s = HREADYOUT_DES;
                    resp_s  = HRESP_DES;
                    rdata_s = HRDATA_DES;
                end else begin
                    ready_s = HREADYOUT_DEF;
                    resp_s  = HRESP_DEF;
                    rdata_s = HRDATA_DEF;
                end
            end
            IC_ERR1: begin
                ready_s = 1'b0;
                resp_s  = 1'b1;
            end
            IC_ERR2: begin
                ready_s = 1'b1;
                resp_s  = 1'b1;
            end
            default: begin
                ready_s = 1'b1;
                resp_s  = 1'b0;
            end
        endcase
    end

    // Data-phase select, sticky abort flags and the saturating error counter.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_r          <= SEL_DEF;
            timeout_flag_r <= 1'b0;
            quarantine_r   <= 1'b0;
            err_count_r    <= 8'd0;
        end else begin
            if (ready_s) begin
                sel_r <= hit_s ? SEL_DES : SEL_DEF;
            end else begin
                sel_r <= sel_r;
            end
            if (expire_s) begin
                timeout_flag_r <= 1'b1;
                quarantine_r   <= quarantine_r | (sel_r == SEL_DES);
            end else begin
                timeout_flag_r <= timeout_flag_r;
                quarantine_r   <= quarantine_r;
            end
            if (ready_s && resp_s && (err_count_r != 8'd255)) begin
                err_count_r <= err_count_r + 8'd1;
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

endmodule

// File: doc/ahb_interconnect.md
# ahb_interconnect

Single-master AHB-Lite interconnect between the bus master and the two slaves in the Triple-DES system: the DES register slave and the default slave that absorbs unmapped addresses. Decodes the address phase into one-hot slave selects, registers the selection for the data phase and multiplexes the selected slave's HREADYOUT/HRESP/HRDATA back to the master. A wait-state watchdog aborts a hung DES slave with a two-cycle ERROR response. After an abort, DES addresses are routed to the default slave.

## Interface
Parameters:
- DES_BASE, 32'h0000_0000, base address of the DES region
- DES_MASK, 32'hFFFF_F000, address bits compared against DES_BASE (4 KB region)
- TIMEOUT, 16, consecutive wait cycles tolerated before abort (≥2)
- DATA_W, 64, data bus width

Ports:
- HCLK  in  1  bus clock, all logic on rising edge
- HRESET  in  1  reset, synchronous, active-high
- HADDR  in  32  master address
- HTRANS  in  2  master transfer type; bit 1 set = NONSEQ/SEQ (valid transfer)
- HSEL_DES  out  1  address-phase select, DES slave
- HSEL_DEF  out  1  address-phase select, default slave
- HREADYOUT_DES / HREADYOUT_DEF  in  1  slave ready
- HRESP_DES / HRESP_DEF  in  1  slave response (1 = ERROR)
- HRDATA_DES / HRDATA_DEF  in  DATA_W  slave read data
- HREADY  out  1  to master and both slaves
- HRESP  out  1  to master
- HRDATA  out  DATA_W  to master
- TIMEOUT_FLAG  out  1  sticky, a watchdog abort occurred
- QUARANTINE  out  1  DES region currently redirected to default slave
- ERR_COUNT  out  8  saturating count of transfers completed with ERROR

## Operation
- Decode (combinational): DES hit = ((HADDR & DES_MASK) == DES_BASE) && !QUARANTINE. HSEL_DES = hit; HSEL_DEF = !hit. Always one-hot; not gated by HTRANS.
- Accept: on an edge with HREADY=1, the data-phase select register loads the decoded select. State goes to DATA if HTRANS[1], else IDLE. The wait counter clears.
- States:
  - IDLE: HREADY=1, HRESP=0, HRDATA=0.
  - DATA: HREADY/HRESP/HRDATA come from the registered slave.
  - ERR1: HREADY=0, HRESP=1, HRDATA=0.
  - ERR2: HREADY=1, HRESP=1, HRDATA=0.
- Transitions: IDLE/DATA/ERR2 use the accept rule when HREADY=1. DATA with selected HREADYOUT=0 stays in DATA and the wait counter increments. If the counter equals TIMEOUT-1 while HREADYOUT=0, the next state is ERR1. ERR1 always goes to ERR2.
- Abort side effects, on the DATA→ERR1 edge: TIMEOUT_FLAG<=1. QUARANTINE<=1 if the registered select is DES.
- QUARANTINE and TIMEOUT_FLAG clear only on reset.
- ERR_COUNT increments, saturating at 255, on every edge where HREADY=1 and HRESP=1. This covers both the ERR2 cycle and slave-generated errors.

## Timing
- Reset (edge with HRESET=1): state IDLE, select DEF, wait counter 0, TIMEOUT_FLAG=0, QUARANTINE=0, ERR_COUNT=0. In the following cycle: HREADY=1, HRESP=0, HRDATA=0.
- Reset mid-transfer (any state): the next cycle is IDLE with the values above, regardless of slave HREADYOUT.
- Decode latency is 0 cycles. Response mux latency is 0 cycles from the slave inputs while in DATA.
- Abort: TIMEOUT consecutive DATA cycles with HREADYOUT=0, then ERR1 on cycle TIMEOUT+1, then ERR2 on cycle TIMEOUT+2.
- If HREADYOUT rises in the cycle where the counter is TIMEOUT-1, the transfer completes normally with no abort.
- An address phase presented during ERR2 is accepted, and it is decoded with QUARANTINE already updated.
- Back-to-back transfers are supported: a new address phase is accepted in the same cycle a data phase completes.

## Structure
- Package ahb_ic_pkg:
  - state enum {IC_IDLE, IC_DATA, IC_ERR1, IC_ERR2}
  - slave_sel_t enum {SEL_DEF, SEL_DES}
  - HTRANS constants IDLE/BUSY/NONSEQ/SEQ
- Sub-module ahb_watchdog: wait counter with clear/increment and the TIMEOUT compare, producing an expire pulse.

## Test plan
- Reset then read 0x0000_0010 with DES ready immediately, HRDATA_DES=64'hDEAD_BEEF_0123_4567: HSEL_DES=1 in the address phase; the next cycle shows HREADY=1, HRESP=0 and the same HRDATA.
- Access 0x0000_2000: HSEL_DEF=1. The default slave's HRESP=1 is passed through and ERR_COUNT becomes 1.
- DES holds HREADYOUT=0 for 3 cycles with TIMEOUT=16: HREADY=0 for 3 cycles, then completes. TIMEOUT_FLAG=0.
- DES holds HREADYOUT=0 indefinitely: after 16 wait cycles, ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1). TIMEOUT_FLAG=1, QUARANTINE=1, ERR_COUNT+1. A following access to 0x0000_0010 asserts HSEL_DEF.
- DES raises HREADYOUT exactly on the 16th low cycle: normal completion with HRESP=0 and no flags set.
- Assert HRESET during the 5th wait cycle: the next cycle shows HREADY=1, HRESP=0, all flags 0, ERR_COUNT=0.
